// File: rtl/alarm_msg_scheduler.sv
// Alarm scheduler: latches smoke/vib/bell events and frames them onto a byte UART TX.
// Latency: req sampled at edge E0 -> send_en high in the cycle after E2; bytes paced by over_tx.
// Backpressure: one byte in flight, the next waits for over_tx; bounded by a timeout. Optional macro: ALARM_CHECKSUM_EN.
`timescale 1ns/1ps
module alarm_msg_scheduler #(
    parameter logic [7:0] HDR_BYTE       = 8'hA5,
    parameter int         TX_TIMEOUT_CYC = 50000,
    parameter int         GAP_CYC        = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_smoke,
    input  logic       req_vib,
    input  logic       req_bell,
    input  logic       over_tx,
    output logic [7:0] data_tx,
    output logic       send_en,
    output logic       busy,
    output logic [2:0] pend,
    output logic       tx_err
);

    // One timer serves both the handshake timeout and the inter-frame gap.
    localparam int TMAX = (TX_TIMEOUT_CYC > GAP_CYC) ? TX_TIMEOUT_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TX_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);

`ifdef ALARM_CHECKSUM_EN
    localparam logic [1:0] LAST = 2'd2;   // header, code, checksum
`else
    localparam logic [1:0] LAST = 2'd1;   // header, code
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        SEND  = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic [1:0]    src;        // 0 smoke, 1 vib, 2 bell
    logic [1:0]    src_nxt;
    logic [2:0]    req_vec;
    logic [2:0]    pend_clr;
    logic [2:0]    pend_rset;
    logic          timeout;
    logic [7:0]    code_nxt;
    logic [7:0]    byte_nxt;

    assign req_vec = {req_bell, req_vib, req_smoke};
    assign tx_err  = timeout;

    // Next-state logic: fixed-priority grant, byte sequencing, timeout and gap handling.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        src_nxt   = src;
        pend_clr  = 3'b000;
        pend_rset = 3'b000;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (|pend) state_nxt = GRANT;
            end
            GRANT: begin
                if (pend[0])      src_nxt = 2'd0;
                else if (pend[1]) src_nxt = 2'd1;
                else              src_nxt = 2'd2;
                pend_clr  = 3'b001 << src_nxt;
                idx_nxt   = 2'd0;
                state_nxt = SEND;
            end
            SEND: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (over_tx) begin
                    if (idx == LAST) begin
                        state_nxt = GAP;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = SEND;
                    end
                end else if (timer == TO_LAST) begin
                    // Aborted frame: put its source back in the queue for a retry.
                    timeout   = 1'b1;
                    pend_rset = 3'b001 << src;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (timer == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte to load into data_tx when entering SEND.
    always_comb begin
        code_nxt = 8'(src_nxt) + 8'd1;
        case (idx_nxt)
            2'd0:    byte_nxt = HDR_BYTE;
            2'd1:    byte_nxt = code_nxt;
`ifdef ALARM_CHECKSUM_EN
            2'd2:    byte_nxt = HDR_BYTE ^ code_nxt;
`endif
            default: byte_nxt = HDR_BYTE;
        endcase
    end

    // State, timer, pending flags and registered TX outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            idx     <= 2'd0;
            src     <= 2'd0;
            pend    <= 3'b000;
            send_en <= 1'b0;
            busy    <= 1'b0;
            data_tx <= 8'h00;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            src   <= src_nxt;
            // Timer restarts on every state change and saturates instead of wrapping.
            if (state_nxt != state) timer <= '0;
            else if (~&timer)       timer <= timer + 1'b1;
            // A new request in the same cycle as the grant clear keeps the flag set.
            pend    <= (pend & ~pend_clr) | req_vec | pend_rset;
            send_en <= (state_nxt == SEND);
            busy    <= (state_nxt != IDLE);
            if (state_nxt == SEND) data_tx <= byte_nxt;
        end
    end

endmodule

// File: tb/tb_alarm_msg_scheduler.sv
// Bench for alarm_msg_scheduler: table-driven single-frame timeline, directed corner
// sequences (simultaneous requests, timeout retry, re-request in flight, reset mid-frame)
// and a randomized phase checked against a transaction-level pending/priority model.
`timescale 1ns/1ps
module tb_alarm_msg_scheduler;
    localparam int         T   = 200;
    localparam int         G   = 20;
    localparam logic [7:0] HDR = 8'hA5;
`ifdef ALARM_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_smoke = 1'b0;
    logic       req_vib = 1'b0;
    logic       req_bell = 1'b0;
    logic       over_tx = 1'b0;
    logic [7:0] data_tx;
    logic       send_en;
    logic       busy;
    logic [2:0] pend;
    logic       tx_err;

    always #5 clk = ~clk;

    alarm_msg_scheduler #(.HDR_BYTE(HDR), .TX_TIMEOUT_CYC(T), .GAP_CYC(G)) dut (
        .clk(clk), .rst_n(rst_n), .req_smoke(req_smoke), .req_vib(req_vib),
        .req_bell(req_bell), .over_tx(over_tx), .data_tx(data_tx), .send_en(send_en),
        .busy(busy), .pend(pend), .tx_err(tx_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input logic [7:0] code, input int i);
        if (i == 0) return HDR;
        if (i == 1) return code;
        return HDR ^ code;
    endfunction

    // Inputs change 1 ns after the rising edge; outputs are observed on the falling edge.
    task automatic step(input logic [2:0] r, input logic o);
        @(posedge clk);
        #1;
        {req_bell, req_vib, req_smoke} = r;
        over_tx = o;
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_send(input int limit, output int waited);
        waited = 0;
        while (send_en !== 1'b1 && waited < limit) begin
            step(3'b000, 1'b0);
            waited++;
        end
    endtask

    task automatic run_frame(input logic [7:0] code, input int delay, input logic started,
                             input string tag);
        int w;
        if (!started) begin
            wait_send(10, w);
            check({tag, ".hdr_send"}, send_en, 1'b1);
        end
        check({tag, ".b0"}, data_tx, HDR);
        for (int b = 1; b < NB; b++) begin
            repeat (delay) step(3'b000, 1'b0);
            step(3'b000, 1'b1);
            step(3'b000, 1'b0);
            check({tag, ".send"}, send_en, 1'b1);
            check({tag, ".byte"}, data_tx, frame_byte(code, b));
        end
        repeat (delay) step(3'b000, 1'b0);
        step(3'b000, 1'b1);
    endtask

    typedef struct {
        logic [2:0] req;
        logic       ovr;
        logic       snd;
        logic       bsy;
        logic [2:0] pnd;
        logic [7:0] dat;
    } vec_t;
    vec_t tbl [8];

    // Random-phase model state
    logic [2:0] pend_last, req_last, rs_last, pend_now, rs_now, rq;
    logic       outst, o;
    logic [7:0] cur_code, last_dat;
    int         byte_idx, resp_cyc, err_cyc, cur_sel, w, k, s_cyc, n_send;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single bell frame; a spurious over_tx in IDLE and a re-request during WAIT.
        tbl[0] = '{3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00};
        tbl[1] = '{3'b000, 1'b1, 1'b0, 1'b0, 3'b100, 8'h00};
        tbl[2] = '{3'b000, 1'b0, 1'b0, 1'b1, 3'b100, 8'h00};
        tbl[3] = '{3'b000, 1'b0, 1'b1, 1'b1, 3'b000, 8'hA5};
        tbl[4] = '{3'b100, 1'b0, 1'b0, 1'b1, 3'b000, 8'hA5};
        tbl[5] = '{3'b000, 1'b1, 1'b0, 1'b1, 3'b100, 8'hA5};
        tbl[6] = '{3'b000, 1'b0, 1'b1, 1'b1, 3'b100, 8'h03};
        tbl[7] = '{3'b000, 1'b0, 1'b0, 1'b1, 3'b100, 8'h03};

        // Reset state
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        check("rst.send_en", send_en, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.pend", pend, 3'b000);
        check("rst.data_tx", data_tx, 8'h00);
        check("rst.tx_err", tx_err, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Test 1 / bell re-request: table timeline
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].req, tbl[i].ovr);
            check($sformatf("tbl%0d.send_en", i), send_en, tbl[i].snd);
            check($sformatf("tbl%0d.busy", i), busy, tbl[i].bsy);
            check($sformatf("tbl%0d.pend", i), pend, tbl[i].pnd);
            check($sformatf("tbl%0d.data_tx", i), data_tx, tbl[i].dat);
            check($sformatf("tbl%0d.tx_err", i), tx_err, 1'b0);
        end
        for (int b = 2; b < NB; b++) begin
            step(3'b000, 1'b1);
            step(3'b000, 1'b0);
            check("t1.cks_send", send_en, 1'b1);
            check("t1.cks_byte", data_tx, frame_byte(8'h03, b));
            step(3'b000, 1'b0);
        end
        step(3'b000, 1'b1);
        for (int g = 0; g < G; g++) begin
            step(3'b000, 1'b0);
            check("t1.gap_busy", busy, 1'b1);
        end
        step(3'b000, 1'b0);
        check("t1.idle_busy", busy, 1'b0);
        check("t1.idle_pend", pend, 3'b100);
        step(3'b000, 1'b0);
        check("t1.grant_busy", busy, 1'b1);
        step(3'b000, 1'b0);
        check("t1.resend", send_en, 1'b1);
        check("t1.resend_pend", pend, 3'b000);
        run_frame(8'h03, 5, 1'b1, "t1b");
        repeat (G + 5) step(3'b000, 1'b0);

        // Test 2: simultaneous requests served smoke, vib, bell with gaps
        step(3'b111, 1'b0);
        step(3'b000, 1'b0);
        check("t2.pend", pend, 3'b111);
        wait_send(10, w);
        check("t2.pend_after_grant", pend, 3'b110);
        run_frame(8'h01, 3, 1'b0, "t2a");
        wait_send(G + 10, w);
        check("t2.gap1", w, G + 3);
        run_frame(8'h02, 3, 1'b1, "t2b");
        wait_send(G + 10, w);
        check("t2.gap2", w, G + 3);
        run_frame(8'h03, 3, 1'b1, "t2c");
        repeat (G + 5) step(3'b000, 1'b0);
        check("t2.drained", {busy, pend}, 4'b0000);

        // Test 3: no over_tx -> timeout, re-pend, retry after gap
        step(3'b010, 1'b0);
        wait_send(10, w);
        check("t3.send", send_en, 1'b1);
        k = 0;
        while (tx_err !== 1'b1 && k < T + 10) begin
            step(3'b000, 1'b0);
            k++;
        end
        check("t3.timeout_cycles", k, T);
        step(3'b000, 1'b0);
        check("t3.err_one_cycle", tx_err, 1'b0);
        check("t3.repend", pend, 3'b010);
        wait_send(G + 10, w);
        check("t3.retry_gap", w, G + 2);
        run_frame(8'h02, 4, 1'b1, "t3r");
        repeat (G + 5) step(3'b000, 1'b0);

        // Test 4: vib re-requested while its frame is in WAIT
        step(3'b010, 1'b0);
        wait_send(10, w);
        step(3'b000, 1'b0);
        step(3'b010, 1'b0);
        step(3'b000, 1'b0);
        check("t4.repend", pend, 3'b010);
        run_frame(8'h02, 2, 1'b1, "t4a");
        wait_send(G + 10, w);
        check("t4.second_gap", w, G + 3);
        run_frame(8'h02, 2, 1'b1, "t4b");
        repeat (G + 5) step(3'b000, 1'b0);

        // Test 5: reset during WAIT of a smoke frame
        step(3'b001, 1'b0);
        wait_send(10, w);
        step(3'b000, 1'b0);
        step(3'b101, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t5.send_en", send_en, 1'b0);
        check("t5.busy", busy, 1'b0);
        check("t5.pend", pend, 3'b000);
        check("t5.data_tx", data_tx, 8'h00);
        check("t5.tx_err", tx_err, 1'b0);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        #3 rst_n = 1'b1;
        n_send = 0;
        repeat (50) begin
            step(3'b000, 1'b1);
            if (send_en === 1'b1 || busy === 1'b1) n_send++;
        end
        check("t5.quiet_after_reset", n_send, 0);

        // Randomized phase against a transaction-level model
        pend_last = 3'b000; req_last = 3'b000; rs_last = 3'b000;
        outst = 1'b0; byte_idx = 0; resp_cyc = -1; err_cyc = -1;
        cur_code = 8'h00; cur_sel = 0; last_dat = data_tx;
        for (int n = 0; n < 6500; n++) begin
            rq = 3'b000;
            if (n < 5000)
                for (int s = 0; s < 3; s++) if ($urandom_range(0, 59) == 0) rq[s] = 1'b1;
            o = 1'b0;
            if (outst && (cyc + 1) == resp_cyc) o = 1'b1;
            else if (!outst && $urandom_range(0, 29) == 0) o = 1'b1;
            step(rq, o);

            check("rnd.tx_err", tx_err, (cyc == err_cyc));
            pend_now = pend_last | req_last | rs_last;
            rs_now = 3'b000;
            if (send_en === 1'b1) begin
                check("rnd.send_while_waiting", outst, 1'b0);
                if (byte_idx == 0) begin
                    check("rnd.grant_nonempty", (pend_last != 3'b000), 1'b1);
                    cur_sel = pend_last[0] ? 0 : (pend_last[1] ? 1 : 2);
                    cur_code = 8'(cur_sel + 1);
                    pend_now[cur_sel] = req_last[cur_sel] | rs_last[cur_sel];
                end
                check("rnd.data_tx", data_tx, frame_byte(cur_code, byte_idx));
                byte_idx++;
                outst = 1'b1;
                if (n < 5000 && $urandom_range(0, 9) == 0) begin
                    err_cyc = cyc + T;
                    resp_cyc = -1;
                end else begin
                    resp_cyc = cyc + $urandom_range(1, 30);
                    err_cyc = -1;
                end
            end else begin
                check("rnd.data_hold", data_tx, last_dat);
            end
            last_dat = data_tx;
            check("rnd.pend", pend, pend_now);
            if (o && outst && cyc == resp_cyc) begin
                outst = 1'b0;
                if (byte_idx == NB) byte_idx = 0;
            end
            if (cyc == err_cyc) begin
                rs_now[cur_sel] = 1'b1;
                outst = 1'b0;
                byte_idx = 0;
                err_cyc = -1;
            end
            pend_last = pend_now;
            req_last = rq;
            rs_last = rs_now;
        end
        check("rnd.drained", {busy, pend}, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
